// File: rtl/sram.sv
// Synchronous 1R/1W SRAM with per-word write enables; data array of the L1 data cache.
// Reads are registered and read-first on same-address collisions; reset only clears readData.
module sram #(
   parameter int wordsize = 64,
   parameter int width    = 512,
   parameter int logDepth = 9
) (
   input  logic                         clk,
   input  logic [logDepth-1:0]          readAddr,
   output logic [width-1:0]             readData,
   input  logic [logDepth-1:0]          writeAddr,
   input  logic [width-1:0]             writeData,
   input  logic [width/wordsize-1:0]    writeEnable,
   input  logic                         reset
);

   localparam int NWORDS = width / wordsize;
   localparam int DEPTH  = 1 << logDepth;

   logic [width-1:0] mem [DEPTH];

   // Array contents survive reset; reset only blocks writes on the edges it is sampled high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NWORDS; i++) begin
            if (writeEnable[i]) begin
               mem[writeAddr][i*wordsize +: wordsize] <= writeData[i*wordsize +: wordsize];
            end
         end
      end
   end

   // Non-blocking read of mem gives read-first behaviour against a same-edge write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readData <= '0;
      end else begin
         readData <= mem[readAddr];
      end
   end

endmodule

// File: tb/tb_sram.sv
// Directed self-checking bench for sram: reset, full/partial writes, collisions,
// concurrent ports and address extremes.
module tb_sram;

   logic         clk;
   logic         reset;
   logic [8:0]   readAddr;
   logic [511:0] readData;
   logic [8:0]   writeAddr;
   logic [511:0] writeData;
   logic [7:0]   writeEnable;

   int errors = 0;
   int checks = 0;

   sram #(.wordsize(64), .width(512), .logDepth(9)) dut (
      .clk         (clk),
      .readAddr    (readAddr),
      .readData    (readData),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .writeEnable (writeEnable),
      .reset       (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] fill(input logic [63:0] w);
      logic [511:0] r;
      for (int i = 0; i < 8; i++) r[i*64 +: 64] = w;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [511:0] exp);
      checks++;
      assert (readData === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, readData, exp);
      end
   endtask

   logic [511:0] blk_a, part_exp, val_a, val_b, v100, v0, lo_blk, hi_blk;

   initial begin
      reset       = 1'b0;
      readAddr    = '0;
      writeAddr   = '0;
      writeData   = '0;
      writeEnable = '0;
      #1 reset = 1'b1;
      #2;
      check("reset_init", '0);
      tick();
      tick();
      reset = 1'b0;

      // Full write / read of entry 5
      for (int i = 0; i < 8; i++) blk_a[i*64 +: 64] = 64'hDEADBEEF_00000000 + 64'(i);
      writeAddr = 9'h005; writeData = blk_a; writeEnable = 8'hFF;
      tick();
      writeEnable = 8'h00; readAddr = 9'h005;
      tick();
      check("full_rw", blk_a);

      // Partial write of entry 1FF
      writeAddr = 9'h1FF; writeData = fill(64'h1111_1111_1111_1111); writeEnable = 8'hFF;
      tick();
      writeData = fill(64'h2222_2222_2222_2222); writeEnable = 8'b0000_0101;
      tick();
      writeEnable = 8'h00; readAddr = 9'h1FF;
      tick();
      part_exp = fill(64'h1111_1111_1111_1111);
      part_exp[0*64 +: 64] = 64'h2222_2222_2222_2222;
      part_exp[2*64 +: 64] = 64'h2222_2222_2222_2222;
      check("partial", part_exp);

      // Same-address collision is read-first
      val_a = fill(64'hAAAA_0000_AAAA_0001);
      val_b = fill(64'hBBBB_0000_BBBB_0002);
      writeAddr = 9'h010; writeData = val_a; writeEnable = 8'hFF;
      tick();
      readAddr = 9'h010; writeData = val_b;
      tick();
      check("collide_old", val_a);
      writeEnable = 8'h00;
      tick();
      check("collide_new", val_b);

      // Concurrent ports: write 000 while reading 100
      v100 = fill(64'h0100_0100_0100_0100);
      writeAddr = 9'h100; writeData = v100; writeEnable = 8'hFF;
      tick();
      readAddr = 9'h100; writeAddr = 9'h000;
      for (int k = 0; k < 16; k++) begin
         v0 = fill(64'hA5A5_0000_0000_0000 + 64'(k));
         writeData = v0;
         tick();
         check($sformatf("concurrent_%0d", k), v100);
      end
      writeEnable = 8'h00; readAddr = 9'h000;
      tick();
      check("concurrent_last", v0);

      // Address extremes: no aliasing between 000 and 1FF
      lo_blk = fill(64'h0000_0000_0000_0F0F);
      hi_blk = fill(64'hFFFF_0000_1FF0_1FF0);
      writeAddr = 9'h000; writeData = lo_blk; writeEnable = 8'hFF;
      tick();
      writeAddr = 9'h1FF; writeData = hi_blk;
      tick();
      writeEnable = 8'h00; readAddr = 9'h000;
      tick();
      check("extreme_lo", lo_blk);
      readAddr = 9'h1FF;
      tick();
      check("extreme_hi", hi_blk);

      // Reset mid-cycle: readData clears at once, writes blocked, contents kept
      readAddr = 9'h005;
      tick();
      check("pre_reset", blk_a);
      #3;
      reset = 1'b1;
      writeAddr = 9'h005; writeData = fill(64'hBAD0_BAD0_BAD0_BAD0); writeEnable = 8'hFF;
      #1;
      check("reset_async", '0);
      tick();
      check("reset_hold", '0);
      tick();
      reset = 1'b0; writeEnable = 8'h00;
      tick();
      check("reset_persist", blk_a);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram.md
# sram

Single-clock, one-read-port / one-write-port synchronous SRAM holding `2^logDepth` entries of `width` bits. Each entry is split into `width/wordsize` words with independent word write enables. It serves as the data array of the L1 data cache. The cache indexes it with `{way, set index}` and reads or writes whole 512-bit blocks.

## Interface
Parameters (positional order):
- `wordsize`, default 64: bits per word. It is the write-enable granularity.
- `width`, default 512: bits per entry. It must be an integer multiple of `wordsize`.
- `logDepth`, default 9: address width. Depth is `2^logDepth` = 512 entries.

Ports:
- `clk`, input, 1: the single clock. All sampling happens on its rising edge.
- `reset`, input, 1: reset is asynchronous and active-high.
- `readAddr`, input, `logDepth`: read entry address.
- `readData`, output, `width`: registered read data.
- `writeAddr`, input, `logDepth`: write entry address.
- `writeData`, input, `width`: write data. Word i is bits `[i*wordsize +: wordsize]`.
- `writeEnable`, input, `width/wordsize` (8): per-word write enable. Bit i controls word i.

Positional connection order is `clk, readAddr, readData, writeAddr, writeData, writeEnable, reset`. `reset` is last so that existing positional instantiations keep their mapping.

## Operation
- Storage is `2^logDepth` × `width` bits. It has no tags and no valid bits, and it does no address decoding beyond `logDepth` bits. Every address is in range.
- **Read**
  - Every rising edge with `reset` low: `readData <= mem[readAddr]`.
  - Reads are unconditional. There is no read enable.
- **Write**
  - Every rising edge with `reset` low: for each i with `writeEnable[i]=1`, `mem[writeAddr]` word i takes word i of `writeData`.
  - Words whose enable is 0 keep their contents.
  - `writeEnable = 0` means no write.
- **Read and write on the same edge, same address:** read-first. `readData` returns the entry contents from before the edge. The new data is visible to a read on the following edge.
- **Read and write on the same edge, different addresses:** both operations proceed independently.
- **Reset**
  - Assertion immediately forces `readData` to 0, independent of `clk`.
  - While `reset` is high, no writes occur and `readData` holds 0.
  - Array contents are not cleared and persist across reset.
  - On the first rising edge after `reset` deasserts, normal reads and writes resume.
- **Never-written entries:** read contents are undefined (X in simulation). Users must write an entry before reading it. The cache guarantees this through its valid bits.
- No error or status outputs exist. Because `2^logDepth` fills the address space, there is no overflow condition.

## Timing
- Read latency is 1 cycle.
  - An address presented before edge N appears on `readData` after edge N.
  - `readData` stays stable until the next edge.
  - Consumers that wait one extra cycle, as the cache does with `delay=1`, see the same value as long as `readAddr` is held.
- A write commits at the edge where `writeEnable` is sampled nonzero.
  - A read of that address sampled at edge N+1 or later returns the new data.
- Holding `writeEnable` asserted over several edges rewrites the same data each cycle. This is harmless.
- There is no handshake and no stall. The array accepts one read and one write every cycle.
- Reset takes effect combinationally on `readData`. Its release is synchronous with respect to operation resumption.

## Test plan
- **Reset:** assert `reset` mid-cycle. `readData` drops to 0 before the next edge. With `writeEnable=8'hFF` held during reset, no entry changes. A later read shows the prior contents.
- **Full write/read:**
  - Write `writeAddr=9'h005`, `writeData` = 512 bits of `64'hDEADBEEF_00000000+i` in word i, `writeEnable=8'hFF`.
  - Set `readAddr=9'h005` on the next cycle. After one edge, `readData` equals the written block exactly.
- **Partial write:**
  - Entry `9'h1FF` holds all `64'h1111...`.
  - Write all `64'h2222...` with `writeEnable=8'b0000_0101`.
  - Read back: words 0 and 2 are `2222...`, words 1 and 3–7 are `1111...`.
- **Same-address collision:**
  - Entry `9'h010` holds A.
  - On one edge, read `9'h010` and write B (`writeEnable=8'hFF`). `readData` = A.
  - On the next edge, read `9'h010`. `readData` = B.
- **Concurrent ports:** write `9'h000` while reading `9'h100` on every cycle for 16 cycles with distinct data. Each read returns the value previously written to `9'h100`, and every write lands.
- **Address extremes:** write distinct blocks to `9'h000` and `9'h1FF`. Each reads back its own block with no aliasing.
